multicycle_phase_sequencer: RTL
===============================

Name: multicycle_phase_sequencer

Overview:
Parametrised successor to the fixed-sequence multicycle control unit. Generates one-hot phase enables (IF, ID, REG, EX, MEM, WB) for the MIPS multicycle datapath from a divided tick of fast_clk. Adds four capabilities:
- configurable memory wait-ticks
- opcode-dependent phase skipping (jump/branch/store/ALU shortcuts)
- pause via top_en
- instruction-boundary freeze for inference/debug readout
Sits between the clock/enable logic and the datapath; outputs drive register-file, ALU and memory write enables.

Parameters:
DIV_COUNT, 4, fast_clk cycles per tick (>=1; 1 = tick every enabled cycle)
MEM_TICKS, 2, ticks spent in IF and in MEM (>=1)
OP_W, 6, opcode width
OP_J, 6'h02, jump opcode
OP_BEQ, 6'h04, branch opcode
OP_LW, 6'h23, load opcode
OP_SW, 6'h2B, store opcode
CNT_W, 16, retired-instruction counter width

Ports:
fast_clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
top_en  in  1  run enable; low pauses divider and state
infer  in  1  freeze request (honoured at instruction boundary)
opcode  in  OP_W  instruction opcode from instruction register
tick_o  out  OP_W-independent 1  divided tick, high for one fast_clk cycle
phase_o  out  6  one-hot {WB,MEM,EX,REG,ID,IF}; 0 in IDLE/FRZ
ju_o  out  1  current instruction is jump (valid REG..end)
br_o  out  1  current instruction is branch
sk_o  out  1  current instruction skips MEM or WB
instr_done  out  1  one-cycle pulse per retired instruction
frozen  out  1  high in FRZ
instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst_n low, async): state IDLE, divider 0, wait counter 0, class latches 0, instr_count 0. All outputs 0.
- Divider: increments only while top_en=1. Wraps at DIV_COUNT-1. tick_o = top_en && div==DIV_COUNT-1 (combinational from registers). The state register advances only on edges where tick_o=1.
- top_en low mid-instruction: divider, wait counter and state hold exactly. phase_o stays asserted.
- phase_o is decoded combinationally from the registered state (one-hot, no glitch between states).
- States and transitions (each arrow taken on a tick):
  - IDLE->IF
  - IF: stays until MEM_TICKS ticks have elapsed, then ->ID
  - ID: latch opcode class (ju/br/lw/sw/alu); ->REG
  - REG->EX
  - EX:
    - jump or branch -> boundary
    - lw -> MEM
    - sw -> MEM
    - alu (any other opcode) -> WB
  - MEM: MEM_TICKS ticks; lw -> WB, sw -> boundary
  - WB -> boundary
- Boundary: next state is FRZ if infer=1 at that tick, else IF.
- Boundary edge effects:
  - instr_done pulses high for exactly one fast_clk cycle (registered, the cycle after the edge).
  - instr_count increments, wrapping at 2^CNT_W.
- sk_o=1 for jump, branch, sw and alu classes. ju_o/br_o follow the latched class. All three clear on entering IF.
- FRZ:
  - phase_o=0, frozen=1.
  - Leaves to IF on the first tick with infer=0; ticks still require top_en.
  - infer asserting mid-instruction has no effect until the boundary.
- Ticks per instruction with MEM_TICKS=m: lw 4+2m, sw 3+2m, alu 4+m, j/beq 3+m.

Optional Feature:
HALT_OPCODE_EN
- Defined:
  - Adds parameter OP_HALT (default 6'h3F) and output halted_o.
  - EX with the halt class -> HALT state: phase_o=0, halted_o=1, instr_done pulses once.
  - HALT is left only by reset; infer/top_en are ignored.
- Undefined: OP_HALT does not exist and that opcode takes the alu path.

Decomposition:
- Shared package holds:
  - state enum (IDLE, IF, ID, REG, EX, MEM, WB, FRZ, HALT)
  - phase bit indices
  - opcode class enum
  - default MIPS opcode constants
- One sub-module: tick_divider (DIV_COUNT, top_en, rst_n -> tick). Reused by the seven-segment refresh logic.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then 1, with top_en=0 → all outputs 0 and state held in IDLE for 20 cycles.
- lw timing: DIV_COUNT=1, MEM_TICKS=1, opcode=6'h23 → phase sequence IF,ID,REG,EX,MEM,WB over 6 cycles (sequence starts on the first tick with top_en=1); sk_o=0; instr_done pulses once; instr_count=1.
- Shortcut paths, same parameters:
  - opcode 6'h02 → 4 ticks, ju_o=1, sk_o=1
  - opcode 6'h2B → 5 ticks, no WB
  - opcode 6'h00 → 5 ticks, no MEM
  - after these three instructions, instr_count=3
- Divider and pause: DIV_COUNT=4, MEM_TICKS=2 → tick_o every 4th cycle; IF lasts 8 cycles. Dropping top_en for 10 cycles mid-EX freezes phase_o=EX and resumes with the remaining divider count.
- Freeze: raise infer during REG → instruction completes, then FRZ with frozen=1 and phase_o=0. Drop infer → IF on the next tick.
- Reset mid-MEM: pull rst_n low → outputs clear immediately (asynchronously); instr_count=0. With HALT_OPCODE_EN defined, opcode 6'h3F → halted_o=1, stays halted across 50 ticks.

Source files
------------

// File: rtl/multicycle_phase_sequencer_pkg.sv
// Shared definitions for the multicycle phase sequencer.
//   state_e  : sequencer states (IDLE, IF, ID, REG, EX, MEM, WB, FRZ, HALT)
//   PH_*     : bit positions of the one-hot phase enables
//   class_e  : latched instruction class, decoded from the opcode in ID
//   *_DEF    : default MIPS opcodes
package multicycle_phase_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_IF,
        ST_ID,
        ST_REG,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_FRZ,
        ST_HALT
    } state_e;

    localparam int unsigned PH_IF  = 0;
    localparam int unsigned PH_ID  = 1;
    localparam int unsigned PH_REG = 2;
    localparam int unsigned PH_EX  = 3;
    localparam int unsigned PH_MEM = 4;
    localparam int unsigned PH_WB  = 5;
    localparam int unsigned PH_W   = 6;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_J,
        CL_BR,
        CL_LW,
        CL_SW,
        CL_ALU,
        CL_HALT
    } class_e;

    localparam logic [5:0] OP_J_DEF    = 6'h02;
    localparam logic [5:0] OP_BEQ_DEF  = 6'h04;
    localparam logic [5:0] OP_LW_DEF   = 6'h23;
    localparam logic [5:0] OP_SW_DEF   = 6'h2B;
    localparam logic [5:0] OP_HALT_DEF = 6'h3F;

    // Classes that bypass MEM or WB (everything except load).
    function automatic logic class_skips(input class_e c);
        return (c == CL_J) || (c == CL_BR) || (c == CL_SW) || (c == CL_ALU);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides the clock into a one-cycle tick every DIV_COUNT enabled cycles.
//   clk_i  : clock
//   rst_n  : asynchronous active-low reset (counter to 0)
//   en_i   : count enable; low holds the counter
//   tick_o : high while enabled and the counter sits at DIV_COUNT-1
module tick_divider #(
    parameter int unsigned DIV_COUNT = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (en_i) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = en_i && (div_q == DIV_LAST);

endmodule

// File: rtl/multicycle_phase_sequencer.sv
// Multicycle MIPS phase sequencer: one-hot IF/ID/REG/EX/MEM/WB enables
// advanced on a divided tick, with opcode-dependent shortcuts, memory
// wait ticks, pause (top_en) and instruction-boundary freeze (infer).
// Optional macro HALT_OPCODE_EN adds OP_HALT and halted_o.
//   fast_clk, rst_n   : clock, async active-low reset
//   top_en            : run enable (pauses divider and state)
//   infer             : freeze request, honoured at instruction boundary
//   opcode            : opcode from the instruction register
//   tick_o            : divided tick
//   phase_o           : one-hot {WB,MEM,EX,REG,ID,IF}
//   ju_o, br_o, sk_o  : latched class flags (jump, branch, skips MEM/WB)
//   instr_done        : one-cycle pulse per retired instruction
//   frozen            : high in FRZ
//   instr_count       : retired instruction count (wraps)
//   halted_o          : high in HALT (HALT_OPCODE_EN only)
module multicycle_phase_sequencer
    import multicycle_phase_sequencer_pkg::*;
#(
    parameter int unsigned     DIV_COUNT = 4,
    parameter int unsigned     MEM_TICKS = 2,
    parameter int unsigned     OP_W      = 6,
    parameter logic [OP_W-1:0] OP_J      = OP_W'(OP_J_DEF),
    parameter logic [OP_W-1:0] OP_BEQ    = OP_W'(OP_BEQ_DEF),
    parameter logic [OP_W-1:0] OP_LW     = OP_W'(OP_LW_DEF),
    parameter logic [OP_W-1:0] OP_SW     = OP_W'(OP_SW_DEF),
`ifdef HALT_OPCODE_EN
    parameter logic [OP_W-1:0] OP_HALT   = OP_W'(OP_HALT_DEF),
`endif
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             fast_clk,
    input  logic             rst_n,
    input  logic             top_en,
    input  logic             infer,
    input  logic [OP_W-1:0]  opcode,
    output logic             tick_o,
    output logic [PH_W-1:0]  phase_o,
    output logic             ju_o,
    output logic             br_o,
    output logic             sk_o,
    output logic             instr_done,
    output logic             frozen,
`ifdef HALT_OPCODE_EN
    output logic             halted_o,
`endif
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (MEM_TICKS > 1) ? $clog2(MEM_TICKS) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TICKS - 1);

    state_e            state_q, state_d;
    class_e            cls_q, cls_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              tick;
    logic              boundary;

    tick_divider #(
        .DIV_COUNT(DIV_COUNT)
    ) u_tick_divider (
        .clk_i  (fast_clk),
        .rst_n  (rst_n),
        .en_i   (top_en),
        .tick_o (tick)
    );

    function automatic class_e decode(input logic [OP_W-1:0] op);
        if (op == OP_J)        return CL_J;
        else if (op == OP_BEQ) return CL_BR;
        else if (op == OP_LW)  return CL_LW;
        else if (op == OP_SW)  return CL_SW;
`ifdef HALT_OPCODE_EN
        else if (op == OP_HALT) return CL_HALT;
`endif
        else                   return CL_ALU;
    endfunction

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        wait_d   = wait_q;
        done_d   = 1'b0;
        count_d  = count_q;
        boundary = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: state_d = ST_IF;
                ST_IF: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_d  = '0;
                        state_d = ST_ID;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_ID: begin
                    cls_d   = decode(opcode);
                    state_d = ST_REG;
                end
                ST_REG: state_d = ST_EX;
                ST_EX: begin
                    case (cls_q)
                        CL_J, CL_BR:  boundary = 1'b1;
                        CL_LW, CL_SW: state_d  = ST_MEM;
                        CL_HALT: begin
                            state_d = ST_HALT;
                            done_d  = 1'b1;
                            count_d = count_q + 1'b1;
                        end
                        default:      state_d  = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_d = '0;
                        if (cls_q == CL_SW) begin
                            boundary = 1'b1;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_WB: boundary = 1'b1;
                ST_FRZ: begin
                    if (!infer) begin
                        state_d = ST_IF;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        if (boundary) begin
            done_d  = 1'b1;
            count_d = count_q + 1'b1;
            state_d = infer ? ST_FRZ : ST_IF;
        end
        // Class flags stay valid through FRZ and drop only when a new
        // instruction fetch begins.
        if ((state_d == ST_IF) && (state_q != ST_IF)) begin
            cls_d = CL_NONE;
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CL_NONE;
            wait_q  <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        phase_o = '0;
        case (state_q)
            ST_IF:   phase_o[PH_IF]  = 1'b1;
            ST_ID:   phase_o[PH_ID]  = 1'b1;
            ST_REG:  phase_o[PH_REG] = 1'b1;
            ST_EX:   phase_o[PH_EX]  = 1'b1;
            ST_MEM:  phase_o[PH_MEM] = 1'b1;
            ST_WB:   phase_o[PH_WB]  = 1'b1;
            default: phase_o = '0;
        endcase
    end

    assign tick_o      = tick;
    assign ju_o        = (cls_q == CL_J);
    assign br_o        = (cls_q == CL_BR);
    assign sk_o        = class_skips(cls_q);
    assign instr_done  = done_q;
    assign frozen      = (state_q == ST_FRZ);
    assign instr_count = count_q;
`ifdef HALT_OPCODE_EN
    assign halted_o    = (state_q == ST_HALT);
`endif

endmodule
